// File: rtl/hdlc_pkg.sv
// Shared constants and state encoding for the HDLC-style framer/deframer pair.
// The FCS-16 values follow the reflected CCITT form used on the link.
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
    localparam logic [7:0]  HDLC_ESC   = 8'h7D;
    localparam logic [7:0]  HDLC_XOR   = 8'h20;

    localparam logic [15:0] FCS16_INIT = 16'hFFFF;
    localparam logic [15:0] FCS16_GOOD = 16'hF0B8;
    localparam logic [15:0] FCS16_POLY = 16'h8408;

    typedef enum logic [1:0] {
        HUNT,
        IDLE,
        DATA,
        ESC
    } hdlc_state_e;

endpackage

// File: rtl/fcs16_byte.sv
// Combinational FCS-16 advance by one byte, LSB first, reflected polynomial.
// Kept standalone so the transmit framer can share it.
module fcs16_byte
    import hdlc_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    always_comb begin
        logic [15:0] c;
        c = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ i_data[i])
                c = (c >> 1) ^ FCS16_POLY;
            else
                c = c >> 1;
        end
        o_crc = c;
    end

endmodule

// File: rtl/hdlc_deframer.sv
// Receive deframer: flag delimiting, escape removal, FCS-16 check, length limit.
// Payload goes out as registered strobes; each frame closes with one status pulse.
module hdlc_deframer
    import hdlc_pkg::*;
#(
    parameter  int MAX_LEN   = 256,
    parameter  int CHECK_FCS = 1,
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_strobe,
    output logic [7:0]    out_data,
    output logic          out_strobe,
    output logic          out_sop,
    output logic          frame_end,
    output logic          frame_ok,
    output logic [LW-1:0] frame_len
);

    hdlc_state_e   r_state, w_state_nxt;
    logic [LW-1:0] r_count, w_count_nxt;
    logic [15:0]   r_crc,   w_crc_nxt;
    logic [7:0]    r_out_data, w_out_data_nxt;
    logic          r_out_strobe, w_out_strobe_nxt;
    logic          r_out_sop, w_out_sop_nxt;
    logic          r_frame_end, w_frame_end_nxt;
    logic          r_frame_ok, w_frame_ok_nxt;
    logic [LW-1:0] r_frame_len, w_frame_len_nxt;

    logic [7:0]    w_byte;
    logic [15:0]   w_crc_upd;
    logic          w_full;
    logic          w_fcs_ok;

    // The only escaped byte is the one following ESC, so unescape here once.
    assign w_byte   = (r_state == ESC) ? (in_data ^ HDLC_XOR) : in_data;
    assign w_full   = (32'(r_count) == MAX_LEN);
    assign w_fcs_ok = (CHECK_FCS == 0) ||
                      ((32'(r_count) >= 3) && (r_crc == FCS16_GOOD));

    fcs16_byte u_fcs (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_upd)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_crc_nxt        = r_crc;
        w_out_data_nxt   = r_out_data;
        w_out_strobe_nxt = 1'b0;
        w_out_sop_nxt    = 1'b0;
        w_frame_end_nxt  = 1'b0;
        w_frame_ok_nxt   = r_frame_ok;
        w_frame_len_nxt  = r_frame_len;

        if (in_strobe) begin
            if (r_state == HUNT) begin
                if (in_data == HDLC_FLAG)
                    w_state_nxt = IDLE;
            end else if (in_data == HDLC_FLAG) begin
                // Closing flag doubles as the next opener; empty frames stay silent.
                if (r_count != '0) begin
                    w_frame_end_nxt = 1'b1;
                    w_frame_ok_nxt  = (r_state == ESC) ? 1'b0 : w_fcs_ok;
                    w_frame_len_nxt = r_count;
                end
                w_state_nxt = IDLE;
                w_count_nxt = '0;
                w_crc_nxt   = FCS16_INIT;
            end else if (r_state != ESC && in_data == HDLC_ESC) begin
                w_state_nxt = ESC;
            end else if (w_full) begin
                w_frame_end_nxt = 1'b1;
                w_frame_ok_nxt  = 1'b0;
                w_frame_len_nxt = LW'(MAX_LEN);
                w_state_nxt     = HUNT;
                w_count_nxt     = '0;
                w_crc_nxt       = FCS16_INIT;
            end else begin
                w_out_strobe_nxt = 1'b1;
                w_out_sop_nxt    = (r_count == '0);
                w_out_data_nxt   = w_byte;
                w_count_nxt      = r_count + 1'b1;
                w_crc_nxt        = w_crc_upd;
                w_state_nxt      = DATA;
            end
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state      <= HUNT;
            r_count      <= '0;
            r_crc        <= FCS16_INIT;
            r_out_data   <= '0;
            r_out_strobe <= 1'b0;
            r_out_sop    <= 1'b0;
            r_frame_end  <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_len  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_crc        <= w_crc_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_strobe <= w_out_strobe_nxt;
            r_out_sop    <= w_out_sop_nxt;
            r_frame_end  <= w_frame_end_nxt;
            r_frame_ok   <= w_frame_ok_nxt;
            r_frame_len  <= w_frame_len_nxt;
        end
    end

    assign out_data   = r_out_data;
    assign out_strobe = r_out_strobe;
    assign out_sop    = r_out_sop;
    assign frame_end  = r_frame_end;
    assign frame_ok   = r_frame_ok;
    assign frame_len  = r_frame_len;

endmodule

// File: tb/tb_hdlc_deframer.sv
// Bench for hdlc_deframer: three configurations share one input stream.
// u0 = FCS checked, u1 = no FCS check, u2 = FCS checked with MAX_LEN=4.
module tb_hdlc_deframer;

    logic       mclk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_strobe;

    logic [7:0] d0, d1, d2;
    logic       s0, s1, s2, p0, p1, p2, e0, e1, e2, k0, k1, k2;
    logic [8:0] l0, l1;
    logic [2:0] l2;

    int pass_cnt = 0;
    int total    = 0;

    logic [7:0]  stim[$];
    logic [15:0] gb[3][$];   // {7'b0, sop, data}
    logic [15:0] gf[3][$];   // {6'b0, ok, len[8:0]}
    logic [15:0] m_b[$];
    logic [15:0] m_f[$];

    always #5 mclk = ~mclk;

    hdlc_deframer #(.MAX_LEN(256), .CHECK_FCS(1)) u0 (
        .mclk(mclk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
        .out_data(d0), .out_strobe(s0), .out_sop(p0),
        .frame_end(e0), .frame_ok(k0), .frame_len(l0));

    hdlc_deframer #(.MAX_LEN(256), .CHECK_FCS(0)) u1 (
        .mclk(mclk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
        .out_data(d1), .out_strobe(s1), .out_sop(p1),
        .frame_end(e1), .frame_ok(k1), .frame_len(l1));

    hdlc_deframer #(.MAX_LEN(4), .CHECK_FCS(1)) u2 (
        .mclk(mclk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
        .out_data(d2), .out_strobe(s2), .out_sop(p2),
        .frame_end(e2), .frame_ok(k2), .frame_len(l2));

    always @(negedge mclk) begin
        if (s0) gb[0].push_back({7'd0, p0, d0});
        if (s1) gb[1].push_back({7'd0, p1, d1});
        if (s2) gb[2].push_back({7'd0, p2, d2});
        if (e0) gf[0].push_back({6'd0, k0, l0});
        if (e1) gf[1].push_back({6'd0, k1, l1});
        if (e2) gf[2].push_back({6'd0, k2, 6'd0, l2});
    end

    function automatic logic [15:0] fcs16(input logic [7:0] q[$], input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ q[i][b]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    // Reference: split the stream at flags, unescape each segment, judge it.
    // A frame is good when its trailing two bytes are the complemented FCS
    // of everything before them, sent low byte first.
    task automatic model(input int maxlen, input bit chk);
        logic [7:0]  fr[$];
        logic [7:0]  b;
        logic [15:0] want;
        int i;
        bit hunting, esc, over, ok;
        m_b.delete(); m_f.delete();
        i = 0; hunting = 1;
        while (i < stim.size()) begin
            if (hunting) begin
                hunting = (stim[i] != 8'h7E);
                i++;
                continue;
            end
            fr.delete(); esc = 0; over = 0;
            while (i < stim.size() && stim[i] != 8'h7E) begin
                b = stim[i]; i++;
                if (!esc && b == 8'h7D) begin esc = 1; continue; end
                if (esc) b = b ^ 8'h20;
                esc = 0;
                if (fr.size() == maxlen) begin over = 1; break; end
                fr.push_back(b);
                m_b.push_back({7'd0, fr.size() == 1, b});
            end
            if (over) begin
                m_f.push_back({6'd0, 1'b0, 9'(maxlen)});
                hunting = 1;
                continue;
            end
            if (i >= stim.size()) break;
            i++;
            if (fr.size() == 0) continue;
            if (esc) ok = 0;
            else if (!chk) ok = 1;
            else if (fr.size() < 3) ok = 0;
            else begin
                want = ~{fr[fr.size()-1], fr[fr.size()-2]};
                ok = (fcs16(fr, fr.size() - 2) == want);
            end
            m_f.push_back({6'd0, ok, 9'(fr.size())});
        end
    endtask

    task automatic do_reset();
        in_strobe = 1'b0;
        in_data   = 8'h00;
        @(posedge mclk);
        #2 reset = 1'b1;
        #10 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            gb[k].delete();
            gf[k].delete();
        end
    endtask

    task automatic send_stim(input int maxgap);
        foreach (stim[i]) begin
            @(posedge mclk);
            #1 in_data = stim[i]; in_strobe = 1'b1;
            @(posedge mclk);
            #1 in_strobe = 1'b0;
            repeat ($urandom_range(maxgap)) @(posedge mclk);
        end
        repeat (3) @(posedge mclk);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_strobe = 1'b0; in_data = 8'h7E;
        #3;
        total++;
        if ({d0, s0, p0, e0, k0, l0} !== '0) $display("FAIL reset_u0: got %h want 0", {d0, s0, p0, e0, k0, l0});
        else pass_cnt++;
        total++;
        if ({d2, s2, p2, e2, k2, l2} !== '0) $display("FAIL reset_u2: got %h want 0", {d2, s2, p2, e2, k2, l2});
        else pass_cnt++;
        #10 reset = 1'b0;
        repeat (5) @(posedge mclk);
        total++;
        if (gb[0].size() + gf[0].size() != 0) $display("FAIL idle_no_output: got %0d events want 0", gb[0].size() + gf[0].size());
        else pass_cnt++;
    endtask

    task automatic test_good_frame();
        logic [7:0] e[$];
        do_reset();
        stim = '{8'h31, 8'hAA, 8'h7E};
        send_stim(1);
        @(posedge mclk);
        #1 in_data = 8'h31; in_strobe = 1'b1;
        @(negedge mclk);
        total++;
        if (s0 !== 1'b0) $display("FAIL latency_early: got %b want 0", s0); else pass_cnt++;
        @(posedge mclk);
        #1 in_strobe = 1'b0;
        @(negedge mclk);
        total++;
        if ({s0, p0, d0} !== {1'b1, 1'b1, 8'h31}) $display("FAIL latency_first: got %h want 331", {s0, p0, d0});
        else pass_cnt++;
        stim = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90, 8'h7E};
        send_stim(2);
        e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
        total++;
        if (gb[0].size() != 11) $display("FAIL good_count: got %0d want 11", gb[0].size()); else pass_cnt++;
        foreach (e[i]) if (i < gb[0].size()) begin
            total++;
            if (gb[0][i] !== {7'd0, i == 0, e[i]}) $display("FAIL good_byte[%0d]: got %h want %h", i, gb[0][i], {7'd0, i == 0, e[i]});
            else pass_cnt++;
        end
        total++;
        if (gf[0].size() != 1 || gf[0][0] !== {6'd0, 1'b1, 9'd11}) $display("FAIL good_end: got n=%0d %h want 20b", gf[0].size(), gf[0].size() ? gf[0][0] : 16'hFFFF);
        else pass_cnt++;
    endtask

    task automatic test_escapes();
        logic [7:0] e[$];
        do_reset();
        stim = '{8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h7D, 8'h20, 8'h7E};
        send_stim(1);
        e = '{8'h7E, 8'h7D, 8'h00};
        total++;
        if (gb[1].size() != 3) $display("FAIL esc_count: got %0d want 3", gb[1].size()); else pass_cnt++;
        foreach (e[i]) if (i < gb[1].size()) begin
            total++;
            if (gb[1][i] !== {7'd0, i == 0, e[i]}) $display("FAIL esc_byte[%0d]: got %h want %h", i, gb[1][i], {7'd0, i == 0, e[i]});
            else pass_cnt++;
        end
        stim = '{8'h7E, 8'h7E};
        send_stim(0);
        total++;
        if (gf[1].size() != 1 || gf[1][0] !== {6'd0, 1'b1, 9'd3}) $display("FAIL esc_end: got n=%0d want 1 frame ok len 3", gf[1].size());
        else pass_cnt++;
    endtask

    task automatic test_bad_fcs();
        do_reset();
        stim = '{8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h91, 8'h7E,
                 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90, 8'h7E};
        send_stim(1);
        total++;
        if (gb[0].size() != 22) $display("FAIL bad_count: got %0d want 22", gb[0].size()); else pass_cnt++;
        total++;
        if (gf[0].size() != 2 || gf[0][0] !== {6'd0, 1'b0, 9'd11} || gf[0][1] !== {6'd0, 1'b1, 9'd11})
            $display("FAIL bad_then_good: got n=%0d first=%h want 00b then 20b", gf[0].size(), gf[0].size() ? gf[0][0] : 16'hFFFF);
        else pass_cnt++;
    endtask

    task automatic test_abort_runt();
        do_reset();
        stim = '{8'h7E, 8'h41, 8'h42, 8'h7D, 8'h7E, 8'h41, 8'h42, 8'h7E};
        send_stim(1);
        total++;
        if (gf[0].size() != 2 || gf[0][0] !== {6'd0, 1'b0, 9'd2} || gf[0][1] !== {6'd0, 1'b0, 9'd2})
            $display("FAIL abort_runt_fcs: got n=%0d want two frames ok=0 len=2", gf[0].size());
        else pass_cnt++;
        total++;
        if (gf[1].size() != 2 || gf[1][0] !== {6'd0, 1'b0, 9'd2} || gf[1][1] !== {6'd0, 1'b1, 9'd2})
            $display("FAIL abort_runt_nofcs: got n=%0d want ok=0 then ok=1, len=2", gf[1].size());
        else pass_cnt++;
    endtask

    task automatic test_overlong();
        do_reset();
        stim = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7E};
        send_stim(2);
        total++;
        if (gb[2].size() != 4 || gb[2][3] !== 16'h0004) $display("FAIL over_count: got %0d want 4", gb[2].size());
        else pass_cnt++;
        total++;
        if (gf[2].size() != 1 || gf[2][0] !== {6'd0, 1'b0, 9'd4}) $display("FAIL over_end: got n=%0d want 1 frame ok=0 len=4", gf[2].size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        stim = '{8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90, 8'h7E, 8'h31, 8'h32};
        send_stim(1);
        @(posedge mclk);
        #3 reset = 1'b1;
        #1;
        total++;
        if ({d0, s0, p0, e0, k0, l0} !== '0) $display("FAIL midreset_outs: got %h want 0", {d0, s0, p0, e0, k0, l0});
        else pass_cnt++;
        #8 reset = 1'b0;
        stim = '{8'h33, 8'h7E};
        send_stim(0);
        total++;
        if (gf[0].size() != 1) $display("FAIL midreset_no_end: got %0d frames want 1", gf[0].size()); else pass_cnt++;
        do_reset();
        stim = '{8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90, 8'h7E};
        send_stim(1);
        total++;
        if (gb[0].size() != 11 || gf[0].size() != 1 || gf[0][0] !== {6'd0, 1'b1, 9'd11})
            $display("FAIL midreset_recover: got bytes=%0d frames=%0d want 11/1 ok", gb[0].size(), gf[0].size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0]  f[$];
        logic [15:0] c;
        int kind, n;
        do_reset();
        stim.delete();
        repeat ($urandom_range(3)) stim.push_back(8'($urandom_range(0, 125)));
        stim.push_back(8'h7E);
        for (int t = 0; t < 40; t++) begin
            f.delete();
            kind = $urandom_range(0, 4);
            n = $urandom_range(0, 7);
            for (int j = 0; j < n; j++)
                f.push_back(($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 8'h7E : 8'h7D) : 8'($urandom));
            if (kind <= 2) begin
                c = ~fcs16(f, f.size());
                f.push_back(c[7:0]);
                f.push_back(c[15:8]);
            end
            if (kind == 1) f[0] = f[0] ^ 8'h01;
            foreach (f[j]) begin
                if (f[j] == 8'h7E || f[j] == 8'h7D) begin
                    stim.push_back(8'h7D);
                    stim.push_back(f[j] ^ 8'h20);
                end else stim.push_back(f[j]);
            end
            if (kind == 3) stim.push_back(8'h7D);
            stim.push_back(8'h7E);
        end
        send_stim(2);
        for (int k = 0; k < 3; k++) begin
            model((k == 2) ? 4 : 256, k != 1);
            total++;
            if (gb[k].size() != m_b.size()) $display("FAIL rand_bytes_n[u%0d]: got %0d want %0d", k, gb[k].size(), m_b.size());
            else pass_cnt++;
            foreach (m_b[i]) if (i < gb[k].size()) begin
                total++;
                if (gb[k][i] !== m_b[i]) $display("FAIL rand_byte[u%0d][%0d]: got %h want %h", k, i, gb[k][i], m_b[i]);
                else pass_cnt++;
            end
            total++;
            if (gf[k].size() != m_f.size()) $display("FAIL rand_frames_n[u%0d]: got %0d want %0d", k, gf[k].size(), m_f.size());
            else pass_cnt++;
            foreach (m_f[i]) if (i < gf[k].size()) begin
                total++;
                if (gf[k][i] !== m_f[i]) $display("FAIL rand_frame[u%0d][%0d]: got %h want %h", k, i, gf[k][i], m_f[i]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_escapes();
        test_bad_fcs();
        test_abort_runt();
        test_overlong();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
